alu_issue: RTL and testbench
============================

Name: alu_issue

Overview:
- Producer side of the ALU interface: decodes RV32I instruction fields into the 4-bit ALU Operation code and selects SrcA/SrcB.
- Holds decoded requests in a 2-entry buffer with a valid/ready handshake toward the ALU/EX stage.
- Sits between the ID stage and the ALU. Also flags illegal encodings so the control path can trap or bubble.

Parameters:
- DATA_WIDTH, 32, operand width
- OPCODE_LENGTH, 4, ALU Operation code width
- DEPTH, 2, buffer entries (fixed at 2; other values not supported)

Ports:
- clk  input  1  rising-edge clock
- reset  input  1  synchronous, active-high reset
- in_valid  input  1  upstream holds a decodable instruction
- in_ready  output  1  buffer can accept this cycle
- Opcode  input  7  instr[6:0]
- Funct3  input  3  instr[14:12]
- Funct7  input  7  instr[31:25]
- RD1  input  DATA_WIDTH  rs1 register data
- RD2  input  DATA_WIDTH  rs2 register data
- Imm  input  DATA_WIDTH  sign-extended immediate from immgen
- flush  input  1  discard all buffered entries
- out_valid  output  1  SrcA/SrcB/Operation valid
- out_ready  input  1  ALU stage consumes this cycle
- SrcA  output  DATA_WIDTH  ALU operand A
- SrcB  output  DATA_WIDTH  ALU operand B
- Operation  output  OPCODE_LENGTH  ALU operation code
- Illegal  output  1  head entry came from an unsupported encoding

Behaviour:
- Decode is combinational. Unlisted Funct3/Funct7 combinations are treated as illegal.
- R-type (0110011), SrcA=RD1, SrcB=RD2:
  - F3=000, F7=0000000 → 0010 ADD
  - F3=000, F7=0100000 → 0011 SUB
  - F3=111 → 0000 AND
  - F3=110 → 0001 OR
  - F3=100 → 0100 XOR
  - F3=010 → 0101 SLT
- I-ALU (0010011), SrcA=RD1, SrcB=Imm:
  - F3=000 → 1011 ADDI
  - F3=010 → 1010 SLTI
  - F3=111 → 0000
  - F3=110 → 0001
  - F3=100 → 0100
- Shifts (within 0010011), SrcB={27'b0, Imm[4:0]}:
  - F3=001, F7=0 → 1100 SLLI
  - F3=101, F7=0 → 1101 SRLI
  - F3=101, F7=0100000 → 1110 SRAI
- LUI (0110111): 1001, SrcA=0, SrcB=Imm.
- Load (0000011) / store (0100011): 0010, SrcA=RD1, SrcB=Imm.
- Branch (1100011), F3=000: 1000 EQ, SrcA=RD1, SrcB=RD2. Every branch operation code has bit[3]=1.
- Illegal encodings: the entry is still enqueued with Operation=0000, SrcA=SrcB=0, Illegal=1.
- Buffer, 2-entry FIFO:
  - push = in_valid & in_ready; pop = out_valid & out_ready.
  - in_ready = (count<2), combinational from registered count only. No combinational path from out_ready to in_ready.
  - out_valid = (count!=0). Outputs always show the head entry.
- Latency: a push into an empty buffer is visible on the outputs the next cycle (1 cycle).
- Boundary conditions:
  - Push and pop in the same cycle with count=1: count stays 1, and the new entry becomes head the next cycle.
  - count=2: in_ready=0 and the push is ignored.
  - Pop while empty: no effect.
  - Outputs are held stable while out_valid=1 and out_ready=0.
- flush: count←0 next cycle. It overrides a same-cycle push and pop, so the incoming instruction is dropped.
- reset, including mid-operation: count←0, out_valid=0, SrcA=SrcB=0, Operation=0000, Illegal=0.
  - in_ready=1 in the cycle after reset.
  - Entry storage is also cleared to 0.

Decomposition:
- alu_pkg holds:
  - RV32I opcode localparams (R_TYPE, I_ALU, LUI, LOAD, STORE, BRANCH).
  - An Operation enum, 4 bits: OP_AND … OP_SRAI, OP_EQ, with the values above.
  - A packed struct alu_req_t {SrcA, SrcB, Operation, Illegal} used for buffer entries.
- Sub-module alu_decode: purely combinational, fields plus RD1/RD2/Imm in, alu_req_t out.
- alu_issue instantiates alu_decode and implements the 2-entry buffer and its control.

Test Plan:
- Reset, then R-type ADD (F3=000, F7=0) with RD1=5, RD2=7, out_ready=1 → next cycle out_valid=1, Operation=0010, SrcA=5, SrcB=7, Illegal=0.
- SRAI with Imm=0x00000403, F7=0100000 → Operation=1110, SrcB=3. LUI with Imm=0x12345000 → Operation=1001, SrcA=0, SrcB=0x12345000.
- out_ready=0 while issuing 3 back-to-back instructions:
  - in_ready drops to 0 after 2 accepts, and the 3rd is held upstream.
  - Outputs stay frozen on the first entry.
  - Raising out_ready drains the entries in order.
- count=1 with simultaneous push and pop for 4 cycles → no bubble, one entry per cycle, count stays 1.
- Opcode=1111111 → Illegal=1, Operation=0000. BEQ with RD1=RD2=9 → Operation=1000 (bit3=1).
- flush with count=2 and in_valid=1 → next cycle out_valid=0, in_ready=1, incoming instruction dropped. Assert reset mid-stream → all outputs 0 next cycle.

Source files
------------

// File: rtl/alu_pkg.sv
// Shared RV32I opcode constants, ALU operation codes and the buffered request
// format used by the ALU issue stage.
package alu_pkg;

  localparam int XLEN = 32;

  localparam logic [6:0] R_TYPE = 7'b0110011;
  localparam logic [6:0] I_ALU  = 7'b0010011;
  localparam logic [6:0] LUI    = 7'b0110111;
  localparam logic [6:0] LOAD   = 7'b0000011;
  localparam logic [6:0] STORE  = 7'b0100011;
  localparam logic [6:0] BRANCH = 7'b1100011;

  localparam logic [6:0] F7_ZERO = 7'b0000000;
  localparam logic [6:0] F7_ALT  = 7'b0100000;

  // Branch comparisons all live in the upper half of the code space (bit 3 set).
  typedef enum logic [3:0] {
    OP_AND  = 4'b0000,
    OP_OR   = 4'b0001,
    OP_ADD  = 4'b0010,
    OP_SUB  = 4'b0011,
    OP_XOR  = 4'b0100,
    OP_SLT  = 4'b0101,
    OP_EQ   = 4'b1000,
    OP_LUI  = 4'b1001,
    OP_SLTI = 4'b1010,
    OP_ADDI = 4'b1011,
    OP_SLLI = 4'b1100,
    OP_SRLI = 4'b1101,
    OP_SRAI = 4'b1110
  } alu_op_e;

  typedef struct packed {
    logic [XLEN-1:0] SrcA;
    logic [XLEN-1:0] SrcB;
    alu_op_e         Operation;
    logic            Illegal;
  } alu_req_t;

  function automatic alu_req_t illegalReq();
    alu_req_t r;
    r.SrcA      = '0;
    r.SrcB      = '0;
    r.Operation = OP_AND;
    r.Illegal   = 1'b1;
    return r;
  endfunction

endpackage

// File: rtl/alu_issue_if.sv
// Handshake bundle between the ID stage, the issue buffer and the ALU stage.
// The issue stage is the slave; whoever feeds it and consumes from it is the master.
interface alu_issue_if #(
  parameter int DATA_WIDTH    = 32,
  parameter int OPCODE_LENGTH = 4
);
  logic                     in_valid;
  logic                     in_ready;
  logic [6:0]               Opcode;
  logic [2:0]               Funct3;
  logic [6:0]               Funct7;
  logic [DATA_WIDTH-1:0]    RD1;
  logic [DATA_WIDTH-1:0]    RD2;
  logic [DATA_WIDTH-1:0]    Imm;
  logic                     flush;
  logic                     out_valid;
  logic                     out_ready;
  logic [DATA_WIDTH-1:0]    SrcA;
  logic [DATA_WIDTH-1:0]    SrcB;
  logic [OPCODE_LENGTH-1:0] Operation;
  logic                     Illegal;

  modport master (
    output in_valid, Opcode, Funct3, Funct7, RD1, RD2, Imm, flush, out_ready,
    input  in_ready, out_valid, SrcA, SrcB, Operation, Illegal
  );

  modport slave (
    input  in_valid, Opcode, Funct3, Funct7, RD1, RD2, Imm, flush, out_ready,
    output in_ready, out_valid, SrcA, SrcB, Operation, Illegal
  );
endinterface

// File: rtl/alu_decode.sv
// Combinational RV32I field decoder: picks the ALU operation and operand sources,
// or produces a zeroed request flagged Illegal for anything it does not support.
module alu_decode
  import alu_pkg::*;
(
  input  logic [6:0]      opcode_i,
  input  logic [2:0]      funct3_i,
  input  logic [6:0]      funct7_i,
  input  logic [XLEN-1:0] rd1_i,
  input  logic [XLEN-1:0] rd2_i,
  input  logic [XLEN-1:0] imm_i,
  output alu_req_t        req_o
);

  logic            legal;
  alu_op_e         op;
  logic [XLEN-1:0] srcA;
  logic [XLEN-1:0] srcB;

  always_comb begin
    legal = 1'b1;
    op    = OP_AND;
    srcA  = rd1_i;
    srcB  = rd2_i;
    unique case (opcode_i)
      R_TYPE: begin
        unique case (funct3_i)
          3'b000: begin
            if (funct7_i == F7_ZERO)     op = OP_ADD;
            else if (funct7_i == F7_ALT) op = OP_SUB;
            else                         legal = 1'b0;
          end
          3'b111:  op = OP_AND;
          3'b110:  op = OP_OR;
          3'b100:  op = OP_XOR;
          3'b010:  op = OP_SLT;
          default: legal = 1'b0;
        endcase
      end
      I_ALU: begin
        srcB = imm_i;
        unique case (funct3_i)
          3'b000: op = OP_ADDI;
          3'b010: op = OP_SLTI;
          3'b111: op = OP_AND;
          3'b110: op = OP_OR;
          3'b100: op = OP_XOR;
          3'b001: begin
            srcB = {{(XLEN-5){1'b0}}, imm_i[4:0]};
            if (funct7_i == F7_ZERO) op = OP_SLLI;
            else                     legal = 1'b0;
          end
          3'b101: begin
            srcB = {{(XLEN-5){1'b0}}, imm_i[4:0]};
            if (funct7_i == F7_ZERO)     op = OP_SRLI;
            else if (funct7_i == F7_ALT) op = OP_SRAI;
            else                         legal = 1'b0;
          end
          default: legal = 1'b0;
        endcase
      end
      LUI: begin
        op   = OP_LUI;
        srcA = '0;
        srcB = imm_i;
      end
      LOAD, STORE: begin
        op   = OP_ADD;
        srcB = imm_i;
      end
      BRANCH: begin
        if (funct3_i == 3'b000) op = OP_EQ;
        else                    legal = 1'b0;
      end
      default: legal = 1'b0;
    endcase
  end

  always_comb begin
    req_o = illegalReq();
    if (legal) begin
      req_o.SrcA      = srcA;
      req_o.SrcB      = srcB;
      req_o.Operation = op;
      req_o.Illegal   = 1'b0;
    end
  end

endmodule

// File: rtl/alu_issue.sv
// ALU issue stage: decodes the incoming instruction and queues it in a 2-entry
// FIFO toward the ALU. in_ready depends only on the registered occupancy.
module alu_issue
  import alu_pkg::*;
#(
  parameter int DATA_WIDTH    = 32,
  parameter int OPCODE_LENGTH = 4,
  parameter int DEPTH         = 2
) (
  input  logic      clk,
  input  logic      reset,
  alu_issue_if.slave bus
);

  localparam logic [1:0] FULL = 2'(DEPTH);

  alu_req_t   decoded;
  alu_req_t   mem_q [2];
  alu_req_t   mem_d [2];
  alu_req_t   head;
  logic [1:0] count_q, count_d;
  logic       rd_q, rd_d;
  logic       wr_q, wr_d;
  logic       push, pop;

  logic [DATA_WIDTH-1:0]    srcAHead;
  logic [DATA_WIDTH-1:0]    srcBHead;
  logic [OPCODE_LENGTH-1:0] opHead;

  alu_decode u_decode (
    .opcode_i (bus.Opcode),
    .funct3_i (bus.Funct3),
    .funct7_i (bus.Funct7),
    .rd1_i    (bus.RD1),
    .rd2_i    (bus.RD2),
    .imm_i    (bus.Imm),
    .req_o    (decoded)
  );

  assign bus.in_ready  = (count_q < FULL);
  assign bus.out_valid = (count_q != 2'd0);
  assign push          = bus.in_valid & bus.in_ready;
  assign pop           = bus.out_valid & bus.out_ready;

  assign head          = mem_q[rd_q];
  assign srcAHead      = head.SrcA;
  assign srcBHead      = head.SrcB;
  assign opHead        = head.Operation;
  assign bus.SrcA      = srcAHead;
  assign bus.SrcB      = srcBHead;
  assign bus.Operation = opHead;
  assign bus.Illegal   = head.Illegal;

  // Flush wins over anything else arriving in the same cycle.
  always_comb begin
    mem_d   = mem_q;
    count_d = count_q;
    rd_d    = rd_q;
    wr_d    = wr_q;
    if (bus.flush) begin
      count_d = 2'd0;
      rd_d    = 1'b0;
      wr_d    = 1'b0;
    end else begin
      if (push) begin
        mem_d[wr_q] = decoded;
        wr_d        = ~wr_q;
      end
      if (pop) begin
        rd_d = ~rd_q;
      end
      count_d = count_q + {1'b0, push} - {1'b0, pop};
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      count_q <= 2'd0;
      rd_q    <= 1'b0;
      wr_q    <= 1'b0;
      for (int i = 0; i < 2; i++) begin
        mem_q[i] <= '0;
      end
    end else begin
      count_q <= count_d;
      rd_q    <= rd_d;
      wr_q    <= wr_d;
      mem_q   <= mem_d;
    end
  end

endmodule

// File: tb/tb_alu_issue.sv
// Scoreboard bench for alu_issue: expected requests are queued as instructions
// are accepted and compared against the head entry as it is consumed.
module tb_alu_issue;

  typedef struct {
    logic [6:0]  op;
    logic [2:0]  f3;
    logic [6:0]  f7;
    logic [31:0] rd1;
    logic [31:0] rd2;
    logic [31:0] imm;
    logic [31:0] ea;
    logic [31:0] eb;
    logic [3:0]  eop;
    logic        eill;
  } stim_t;

  typedef struct packed {
    logic [31:0] a;
    logic [31:0] b;
    logic [3:0]  op;
    logic        ill;
  } exp_t;

  logic clk = 1'b0;
  logic reset;
  int   compared;
  int   mismatched;
  exp_t sb[$];

  always #5 clk = ~clk;

  alu_issue_if #(.DATA_WIDTH(32), .OPCODE_LENGTH(4)) bus ();

  alu_issue #(.DATA_WIDTH(32), .OPCODE_LENGTH(4), .DEPTH(2)) dut (
    .clk   (clk),
    .reset (reset),
    .bus   (bus)
  );

  task automatic drive(input stim_t s);
    bus.in_valid = 1'b1;
    bus.Opcode   = s.op;
    bus.Funct3   = s.f3;
    bus.Funct7   = s.f7;
    bus.RD1      = s.rd1;
    bus.RD2      = s.rd2;
    bus.Imm      = s.imm;
  endtask

  task automatic idle();
    bus.in_valid = 1'b0;
    bus.Opcode   = 7'd0;
    bus.Funct3   = 3'd0;
    bus.Funct7   = 7'd0;
    bus.RD1      = 32'd0;
    bus.RD2      = 32'd0;
    bus.Imm      = 32'd0;
  endtask

  task automatic enqueueExp(input stim_t s);
    sb.push_back({s.ea, s.eb, s.eop, s.eill});
  endtask

  function automatic exp_t headNow();
    return {bus.SrcA, bus.SrcB, bus.Operation, bus.Illegal};
  endfunction

  function automatic exp_t sbFront();
    if (sb.size() == 0) return '1;
    return sb[0];
  endfunction

  task automatic test_reset();
    reset = 1'b1;
    idle();
    bus.flush     = 1'b0;
    bus.out_ready = 1'b0;
    repeat (2) @(negedge clk);
    compared++;
    if ({bus.out_valid, headNow()} !== '0) begin
      mismatched++;
      $display("[TB] FAIL reset_outputs: got valid=%b head=%h want all zero", bus.out_valid, headNow());
    end
    reset = 1'b0;
    @(negedge clk);
    compared++;
    if (bus.in_ready !== 1'b1 || bus.out_valid !== 1'b0) begin
      mismatched++;
      $display("[TB] FAIL reset_ready: got in_ready=%b out_valid=%b want 1/0", bus.in_ready, bus.out_valid);
    end
    bus.out_ready = 1'b1;
    repeat (2) @(negedge clk);
    compared++;
    if (bus.in_ready !== 1'b1 || bus.out_valid !== 1'b0) begin
      mismatched++;
      $display("[TB] FAIL pop_empty: got in_ready=%b out_valid=%b want 1/0", bus.in_ready, bus.out_valid);
    end
  endtask

  task automatic test_add();
    stim_t s;
    s = '{7'b0110011, 3'b000, 7'b0000000, 32'd5, 32'd7, 32'd0, 32'd5, 32'd7, 4'b0010, 1'b0};
    bus.out_ready = 1'b1;
    drive(s);
    enqueueExp(s);
    @(negedge clk);
    idle();
    compared++;
    if (bus.out_valid !== 1'b1 || headNow() !== sbFront()) begin
      mismatched++;
      $display("[TB] FAIL add_head: got valid=%b head=%h want 1 %h", bus.out_valid, headNow(), sbFront());
    end
    if (sb.size() > 0) void'(sb.pop_front());
    @(negedge clk);
    compared++;
    if (bus.out_valid !== 1'b0) begin
      mismatched++;
      $display("[TB] FAIL add_drained: got out_valid=%b want 0", bus.out_valid);
    end
  endtask

  task automatic test_srai_lui();
    stim_t s [2];
    s[0] = '{7'b0010011, 3'b101, 7'b0100000, 32'h8000_0000, 32'd0, 32'h0000_0403,
             32'h8000_0000, 32'd3, 4'b1110, 1'b0};
    s[1] = '{7'b0110111, 3'b000, 7'b0000000, 32'hDEAD_BEEF, 32'd1, 32'h1234_5000,
             32'd0, 32'h1234_5000, 4'b1001, 1'b0};
    bus.out_ready = 1'b1;
    drive(s[0]);
    enqueueExp(s[0]);
    for (int i = 0; i < 2; i++) begin
      @(negedge clk);
      compared++;
      if (bus.out_valid !== 1'b1 || headNow() !== sbFront()) begin
        mismatched++;
        $display("[TB] FAIL srai_lui_head%0d: got valid=%b head=%h want 1 %h", i, bus.out_valid, headNow(), sbFront());
      end
      if (sb.size() > 0) void'(sb.pop_front());
      if (i == 0) begin
        drive(s[1]);
        enqueueExp(s[1]);
      end else begin
        idle();
      end
    end
    @(negedge clk);
    compared++;
    if (bus.out_valid !== 1'b0) begin
      mismatched++;
      $display("[TB] FAIL srai_lui_drained: got out_valid=%b want 0", bus.out_valid);
    end
  endtask

  task automatic test_back_to_back();
    stim_t s [3];
    s[0] = '{7'b0010011, 3'b000, 7'b0000000, 32'd10, 32'd0, 32'hFFFF_FFFF,
             32'd10, 32'hFFFF_FFFF, 4'b1011, 1'b0};
    s[1] = '{7'b0110011, 3'b110, 7'b0000000, 32'h0000_00F0, 32'h0000_000F, 32'd0,
             32'h0000_00F0, 32'h0000_000F, 4'b0001, 1'b0};
    s[2] = '{7'b0010011, 3'b100, 7'b0000000, 32'hAAAA_5555, 32'd0, 32'h0000_FFFF,
             32'hAAAA_5555, 32'h0000_FFFF, 4'b0100, 1'b0};
    bus.out_ready = 1'b0;
    drive(s[0]);
    enqueueExp(s[0]);
    @(negedge clk);
    drive(s[1]);
    enqueueExp(s[1]);
    @(negedge clk);
    drive(s[2]);
    compared++;
    if (bus.in_ready !== 1'b0) begin
      mismatched++;
      $display("[TB] FAIL full_ready: got in_ready=%b want 0", bus.in_ready);
    end
    // Two stalled cycles: third instruction is held and the head must not move.
    for (int i = 0; i < 2; i++) begin
      @(negedge clk);
      compared++;
      if (bus.in_ready !== 1'b0 || bus.out_valid !== 1'b1 || headNow() !== sbFront()) begin
        mismatched++;
        $display("[TB] FAIL frozen_head%0d: got ready=%b valid=%b head=%h want 0 1 %h",
                 i, bus.in_ready, bus.out_valid, headNow(), sbFront());
      end
    end
    bus.out_ready = 1'b1;
    for (int i = 0; i < 3; i++) begin
      compared++;
      if (bus.out_valid !== 1'b1 || headNow() !== sbFront()) begin
        mismatched++;
        $display("[TB] FAIL drain%0d: got valid=%b head=%h want 1 %h", i, bus.out_valid, headNow(), sbFront());
      end
      if (sb.size() > 0) void'(sb.pop_front());
      if (i == 1) begin
        compared++;
        if (bus.in_ready !== 1'b1) begin
          mismatched++;
          $display("[TB] FAIL held_accept: got in_ready=%b want 1", bus.in_ready);
        end
        enqueueExp(s[2]);
      end
      @(negedge clk);
      if (i == 1) idle();
    end
    compared++;
    if (bus.out_valid !== 1'b0) begin
      mismatched++;
      $display("[TB] FAIL b2b_drained: got out_valid=%b want 0", bus.out_valid);
    end
  endtask

  task automatic test_stream();
    stim_t s [5];
    s[0] = '{7'b0110011, 3'b000, 7'b0100000, 32'd100, 32'd30, 32'd0, 32'd100, 32'd30, 4'b0011, 1'b0};
    s[1] = '{7'b0110011, 3'b010, 7'b0000000, 32'd1, 32'd2, 32'd0, 32'd1, 32'd2, 4'b0101, 1'b0};
    s[2] = '{7'b0000011, 3'b010, 7'b0000000, 32'h0000_1000, 32'd0, 32'd8,
             32'h0000_1000, 32'd8, 4'b0010, 1'b0};
    s[3] = '{7'b0100011, 3'b010, 7'b0000000, 32'h0000_2000, 32'd5, 32'hFFFF_FFFC,
             32'h0000_2000, 32'hFFFF_FFFC, 4'b0010, 1'b0};
    s[4] = '{7'b0010011, 3'b001, 7'b0000000, 32'd7, 32'd0, 32'd5, 32'd7, 32'd5, 4'b1100, 1'b0};
    bus.out_ready = 1'b1;
    drive(s[0]);
    enqueueExp(s[0]);
    for (int i = 1; i <= 5; i++) begin
      @(negedge clk);
      compared++;
      if (bus.out_valid !== 1'b1 || bus.in_ready !== 1'b1 || headNow() !== sbFront()) begin
        mismatched++;
        $display("[TB] FAIL stream%0d: got valid=%b ready=%b head=%h want 1 1 %h",
                 i, bus.out_valid, bus.in_ready, headNow(), sbFront());
      end
      if (sb.size() > 0) void'(sb.pop_front());
      if (i < 5) begin
        drive(s[i]);
        enqueueExp(s[i]);
      end else begin
        idle();
      end
    end
    @(negedge clk);
    compared++;
    if (bus.out_valid !== 1'b0) begin
      mismatched++;
      $display("[TB] FAIL stream_drained: got out_valid=%b want 0", bus.out_valid);
    end
  endtask

  task automatic test_illegal_branch();
    stim_t s [6];
    s[0] = '{7'b1111111, 3'b000, 7'b0000000, 32'd11, 32'd22, 32'd33, 32'd0, 32'd0, 4'b0000, 1'b1};
    s[1] = '{7'b1100011, 3'b000, 7'b0000000, 32'd9, 32'd9, 32'h10, 32'd9, 32'd9, 4'b1000, 1'b0};
    s[2] = '{7'b0110011, 3'b000, 7'b0000001, 32'd3, 32'd4, 32'd0, 32'd0, 32'd0, 4'b0000, 1'b1};
    s[3] = '{7'b1100011, 3'b001, 7'b0000000, 32'd9, 32'd8, 32'd4, 32'd0, 32'd0, 4'b0000, 1'b1};
    s[4] = '{7'b0010011, 3'b101, 7'b0000000, 32'hFFFF_0000, 32'd0, 32'h0000_0010,
             32'hFFFF_0000, 32'h0000_0010, 4'b1101, 1'b0};
    s[5] = '{7'b0010011, 3'b111, 7'b0000000, 32'h0000_F0F0, 32'd0, 32'h0000_00FF,
             32'h0000_F0F0, 32'h0000_00FF, 4'b0000, 1'b0};
    bus.out_ready = 1'b1;
    drive(s[0]);
    enqueueExp(s[0]);
    for (int i = 1; i <= 6; i++) begin
      @(negedge clk);
      compared++;
      if (bus.out_valid !== 1'b1 || headNow() !== sbFront()) begin
        mismatched++;
        $display("[TB] FAIL decode%0d: got valid=%b head=%h want 1 %h", i - 1, bus.out_valid, headNow(), sbFront());
      end
      if (sb.size() > 0) void'(sb.pop_front());
      if (i < 6) begin
        drive(s[i]);
        enqueueExp(s[i]);
      end else begin
        idle();
      end
    end
    @(negedge clk);
  endtask

  task automatic test_flush();
    stim_t a;
    stim_t b;
    a = '{7'b0110011, 3'b000, 7'b0000000, 32'd1, 32'd1, 32'd0, 32'd1, 32'd1, 4'b0010, 1'b0};
    b = '{7'b0110111, 3'b000, 7'b0000000, 32'd0, 32'd0, 32'h0000_7000, 32'd0, 32'h0000_7000, 4'b1001, 1'b0};
    bus.out_ready = 1'b0;
    drive(a);
    @(negedge clk);
    drive(b);
    @(negedge clk);
    bus.flush     = 1'b1;
    bus.out_ready = 1'b1;
    drive(a);
    @(negedge clk);
    bus.flush = 1'b0;
    idle();
    compared++;
    if (bus.out_valid !== 1'b0 || bus.in_ready !== 1'b1) begin
      mismatched++;
      $display("[TB] FAIL flush_full: got valid=%b ready=%b want 0 1", bus.out_valid, bus.in_ready);
    end
    bus.out_ready = 1'b0;
    drive(a);
    @(negedge clk);
    bus.flush     = 1'b1;
    bus.out_ready = 1'b1;
    drive(b);
    @(negedge clk);
    bus.flush = 1'b0;
    idle();
    compared++;
    if (bus.out_valid !== 1'b0 || bus.in_ready !== 1'b1) begin
      mismatched++;
      $display("[TB] FAIL flush_drops_push: got valid=%b ready=%b want 0 1", bus.out_valid, bus.in_ready);
    end
    @(negedge clk);
    compared++;
    if (bus.out_valid !== 1'b0) begin
      mismatched++;
      $display("[TB] FAIL flush_stays_empty: got out_valid=%b want 0", bus.out_valid);
    end
    sb.delete();
  endtask

  task automatic test_reset_mid();
    stim_t a;
    stim_t b;
    a = '{7'b0110011, 3'b100, 7'b0000000, 32'h1234_5678, 32'h0F0F_0F0F, 32'd0,
          32'h1234_5678, 32'h0F0F_0F0F, 4'b0100, 1'b0};
    b = '{7'b1111111, 3'b111, 7'b1111111, 32'd1, 32'd2, 32'd3, 32'd0, 32'd0, 4'b0000, 1'b1};
    bus.out_ready = 1'b0;
    drive(a);
    @(negedge clk);
    drive(b);
    @(negedge clk);
    reset = 1'b1;
    drive(a);
    @(negedge clk);
    compared++;
    if ({bus.out_valid, headNow()} !== '0) begin
      mismatched++;
      $display("[TB] FAIL reset_mid_outputs: got valid=%b head=%h want all zero", bus.out_valid, headNow());
    end
    reset = 1'b0;
    idle();
    @(negedge clk);
    compared++;
    if (bus.in_ready !== 1'b1 || bus.out_valid !== 1'b0) begin
      mismatched++;
      $display("[TB] FAIL reset_mid_ready: got ready=%b valid=%b want 1 0", bus.in_ready, bus.out_valid);
    end
    sb.delete();
    bus.out_ready = 1'b1;
    drive(a);
    enqueueExp(a);
    @(negedge clk);
    idle();
    compared++;
    if (bus.out_valid !== 1'b1 || headNow() !== sbFront()) begin
      mismatched++;
      $display("[TB] FAIL after_reset_head: got valid=%b head=%h want 1 %h", bus.out_valid, headNow(), sbFront());
    end
    if (sb.size() > 0) void'(sb.pop_front());
    @(negedge clk);
  endtask

  initial begin
    compared   = 0;
    mismatched = 0;
    reset      = 1'b1;
    idle();
    bus.flush     = 1'b0;
    bus.out_ready = 1'b0;
    test_reset();
    test_add();
    test_srai_lui();
    test_back_to_back();
    test_stream();
    test_illegal_branch();
    test_flush();
    test_reset_mid();
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
    $finish;
  end

endmodule
